// File: rtl/viterbi_frame_ctrl_if.sv
// viterbi_frame_ctrl_if: payload stream, encoder drive and decoder return signals
// of the frame sequencer.
interface viterbi_frame_ctrl_if #(parameter int CW = 7);
  logic start_i, bit_i, bit_valid_i, bit_ready_o;
  logic enc_en_o, enc_d_o, dec_bit_i, dec_bit_o, dec_valid_o;
  logic busy_o, done_o;
  logic [CW-1:0] err_cnt_o;
  modport master (
    output start_i, bit_i, bit_valid_i, dec_bit_i,
    input bit_ready_o, enc_en_o, enc_d_o, dec_bit_o, dec_valid_o, busy_o, done_o, err_cnt_o
  );
  modport slave (
    input start_i, bit_i, bit_valid_i, dec_bit_i,
    output bit_ready_o, enc_en_o, enc_d_o, dec_bit_o, dec_valid_o, busy_o, done_o, err_cnt_o
  );
endinterface

// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl: sequences one payload frame into the encoder, flushes the trellis
// with zero tail bits, realigns the decoder output and counts decoded bit errors.
module viterbi_frame_ctrl #(
  parameter int FRAME_LEN = 64,
  parameter int TAIL_LEN = 2,
  parameter int DEC_LAT = 32,
  localparam int CW = $clog2(FRAME_LEN + 1)
) (
  input logic clk,
  input logic rst,
  viterbi_frame_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PAYLOAD, TAIL, DRAIN, DONE} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] tx_q, tx_d, rx_q, rx_d, err_q, err_d;
  logic [3:0] tail_q, tail_d;
  logic enc_en_q, enc_en_d, enc_d_q, enc_d_d, pay_q, pay_d;
  logic dv_q, dv_d, db_q, db_d;
  logic [DEC_LAT-1:0] tag_q, tag_d, ref_q, ref_d;
  logic acc, tag_out, ref_out;
  assign bus.bit_ready_o = state_q == PAYLOAD;
  assign acc = bus.bit_ready_o & bus.bit_valid_i;
  assign tag_out = tag_q[DEC_LAT-1];
  assign ref_out = ref_q[DEC_LAT-1];
  assign bus.enc_en_o = enc_en_q;
  assign bus.enc_d_o = enc_d_q;
  assign bus.dec_valid_o = dv_q;
  assign bus.dec_bit_o = db_q;
  assign bus.err_cnt_o = err_q;
  assign bus.busy_o = state_q != IDLE;
  assign bus.done_o = state_q == DONE;
  // pay_q tags only payload encoder cycles, so tail and gap cycles never emerge as valids
  always_comb begin
    state_d = state_q;
    tx_d = acc ? tx_q + 1'b1 : tx_q;
    rx_d = rx_q;
    err_d = err_q;
    tail_d = tail_q;
    enc_en_d = acc;
    enc_d_d = acc ? bus.bit_i : enc_d_q;
    pay_d = acc;
    dv_d = tag_out;
    db_d = tag_out ? bus.dec_bit_i : db_q;
    tag_d = DEC_LAT'({tag_q, pay_q});
    ref_d = DEC_LAT'({ref_q, enc_d_q});
    if (tag_out && rx_q != CW'(FRAME_LEN)) begin
      rx_d = rx_q + 1'b1;
      err_d = err_q + CW'(bus.dec_bit_i != ref_out);
    end
    case (state_q)
      IDLE: if (bus.start_i) begin
        state_d = PAYLOAD;
        tx_d = '0;
        rx_d = '0;
        err_d = '0;
        tail_d = '0;
      end
      PAYLOAD: if (acc && tx_q == CW'(FRAME_LEN - 1)) state_d = TAIL_LEN == 0 ? DRAIN : TAIL;
      TAIL: begin
        enc_en_d = 1'b1;
        enc_d_d = 1'b0;
        tail_d = tail_q + 1'b1;
        if (tail_q == 4'(TAIL_LEN - 1)) state_d = DRAIN;
      end
      DRAIN: if (rx_q == CW'(FRAME_LEN)) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      tx_q <= '0;
      rx_q <= '0;
      err_q <= '0;
      tail_q <= '0;
      enc_en_q <= 1'b0;
      enc_d_q <= 1'b0;
      pay_q <= 1'b0;
      dv_q <= 1'b0;
      db_q <= 1'b0;
      tag_q <= '0;
      ref_q <= '0;
    end else begin
      state_q <= state_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      err_q <= err_d;
      tail_q <= tail_d;
      enc_en_q <= enc_en_d;
      enc_d_q <= enc_d_d;
      pay_q <= pay_d;
      dv_q <= dv_d;
      db_q <= db_d;
      tag_q <= tag_d;
      ref_q <= ref_d;
    end
endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// tb_viterbi_frame_ctrl: drives whole frames into two configurations of the sequencer
// and compares per-cycle output traces against a frame-level reference model.
module tb_viterbi_frame_ctrl;
  localparam int DL = 5;
  logic clk = 1'b0, rst = 1'b0, sel = 1'b0;
  logic start = 1'b0, valid = 1'b0, bitv = 1'b0, decb = 1'b0;
  logic o_rdy, o_en, o_d, o_dv, o_db, o_busy, o_done;
  logic [3:0] o_err;
  logic [7:0] hist = '0;
  logic [63:0] t_rdy, t_en, t_d, t_dv, t_db, t_busy, t_done;
  logic [63:0] e_rdy, e_en, e_d, e_dv, e_db, e_busy, e_done;
  logic [3:0] err1, err_end;
  logic [10:0] snap;
  int e_err;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  viterbi_frame_ctrl_if #(.CW(4)) a ();
  viterbi_frame_ctrl_if #(.CW(2)) b ();
  viterbi_frame_ctrl #(.FRAME_LEN(8), .TAIL_LEN(2), .DEC_LAT(DL)) dut_a (.clk(clk), .rst(rst), .bus(a));
  viterbi_frame_ctrl #(.FRAME_LEN(2), .TAIL_LEN(0), .DEC_LAT(DL)) dut_b (.clk(clk), .rst(rst), .bus(b));

  assign a.start_i = !sel && start;
  assign a.bit_valid_i = !sel && valid;
  assign a.bit_i = bitv;
  assign a.dec_bit_i = decb;
  assign b.start_i = sel && start;
  assign b.bit_valid_i = sel && valid;
  assign b.bit_i = bitv;
  assign b.dec_bit_i = decb;
  assign o_rdy = sel ? b.bit_ready_o : a.bit_ready_o;
  assign o_en = sel ? b.enc_en_o : a.enc_en_o;
  assign o_d = sel ? b.enc_d_o : a.enc_d_o;
  assign o_dv = sel ? b.dec_valid_o : a.dec_valid_o;
  assign o_db = sel ? b.dec_bit_o : a.dec_bit_o;
  assign o_busy = sel ? b.busy_o : a.busy_o;
  assign o_done = sel ? b.done_o : a.done_o;
  assign o_err = sel ? {2'b00, b.err_cnt_o} : a.err_cnt_o;

  // channel+decoder stand-in: DL-cycle delay of the encoder data
  always @(posedge clk) hist <= {hist[6:0], o_d};

  // frame-level reference: start at cycle 0, valid pattern vp, payload bits, decoder flips fm
  task automatic model(input int fl, input int tl, input logic [63:0] vp, input logic [7:0] bits, input logic [7:0] fm);
    int k, last, dn;
    k = 0;
    last = 0;
    {e_rdy, e_en, e_d, e_dv, e_db, e_busy, e_done} = '0;
    for (int r = 1; r < 64 && k < fl; r++) begin
      e_rdy[r] = 1'b1;
      if (vp[r]) begin
        e_en[r+1] = 1'b1;
        e_d[r+1] = bits[k];
        e_dv[r+DL+2] = 1'b1;
        e_db[r+DL+2] = bits[k] ^ fm[k];
        last = r;
        k++;
      end
    end
    for (int j = 1; j <= tl; j++) e_en[last+1+j] = 1'b1;
    dn = (last + DL + 2 > last + 1 + tl ? last + DL + 2 : last + 1 + tl) + 1;
    for (int r = 1; r <= dn; r++) e_busy[r] = 1'b1;
    e_done[dn] = 1'b1;
    e_err = $countones(fm & 8'((9'd1 << fl) - 1));
  endtask

  task automatic run_frame(input logic [63:0] vp, input logic [7:0] bits, input logic [7:0] fm, input logic [63:0] sp, input int rst_at);
    int k;
    logic [63:0] flip;
    k = 0;
    flip = '0;
    for (int r = 0; r < 64; r++) begin
      @(negedge clk);
      t_rdy[r] = o_rdy;
      t_en[r] = o_en;
      t_d[r] = o_d;
      t_dv[r] = o_dv;
      t_db[r] = o_db;
      t_busy[r] = o_busy;
      t_done[r] = o_done;
      if (r == 1) err1 = o_err;
      if (r == 63) err_end = o_err;
      start = sp[r];
      valid = r > 0 && vp[r];
      bitv = bits[k[2:0]];
      decb = hist[DL-1] ^ flip[r];
      if (valid && o_rdy && k < 8) begin
        if (r < 58) flip[r+1+DL] = fm[k];
        k++;
      end
      if (r == rst_at) begin
        rst = 1'b0;
        #1 snap = {o_rdy, o_en, o_d, o_dv, o_db, o_busy, o_done, o_err};
      end
      if (r == rst_at + 1) rst = 1'b1;
    end
    start = 1'b0;
    valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    snap = {o_rdy, o_en, o_d, o_dv, o_db, o_busy, o_done, o_err};
    checks++;
    if (snap !== '0) begin errors++; $display("FAIL reset_hold outputs=%h expected 0", snap); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    sel = 1'b1;
    #1 snap = {o_rdy, o_en, o_d, o_dv, o_db, o_busy, o_done, o_err};
    checks++;
    if (snap !== '0) begin errors++; $display("FAIL reset_idle_short outputs=%h expected 0", snap); end
    sel = 1'b0;
    #1 snap = {o_rdy, o_en, o_d, o_dv, o_db, o_busy, o_done, o_err};
    checks++;
    if (snap !== '0) begin errors++; $display("FAIL reset_idle_main outputs=%h expected 0", snap); end
  endtask

  task automatic test_continuous;
    model(8, 2, 64'hFFFF_FFFF_FFFF_FFFE, 8'h4D, 8'h00);
    run_frame(64'hFFFF_FFFF_FFFF_FFFE, 8'h4D, 8'h00, 64'h1, -1);
    checks++;
    if (t_en !== e_en || (t_d & e_en) !== e_d) begin errors++; $display("FAIL cont_enc en=%h d=%h expected en=%h d=%h", t_en, t_d & e_en, e_en, e_d); end
    checks++;
    if (t_dv !== e_dv || (t_db & e_dv) !== e_db) begin errors++; $display("FAIL cont_dec dv=%h db=%h expected dv=%h db=%h", t_dv, t_db & e_dv, e_dv, e_db); end
    checks++;
    if (t_rdy !== e_rdy || t_busy !== e_busy || t_done !== e_done) begin errors++; $display("FAIL cont_ctrl rdy=%h busy=%h done=%h expected %h %h %h", t_rdy, t_busy, t_done, e_rdy, e_busy, e_done); end
    checks++;
    if ($countones(t_en) != 10 || $countones(t_dv) != 8) begin errors++; $display("FAIL cont_counts en=%0d dv=%0d expected 10 8", $countones(t_en), $countones(t_dv)); end
    checks++;
    if (err_end !== 4'(e_err)) begin errors++; $display("FAIL cont_err got=%0d expected=%0d", err_end, e_err); end
  endtask

  task automatic test_flip;
    model(8, 2, 64'hFFFF_FFFF_FFFF_FFFE, 8'h4D, 8'h24);
    run_frame(64'hFFFF_FFFF_FFFF_FFFE, 8'h4D, 8'h24, 64'h1, -1);
    checks++;
    if (t_dv !== e_dv || (t_db & e_dv) !== e_db) begin errors++; $display("FAIL flip_dec dv=%h db=%h expected dv=%h db=%h", t_dv, t_db & e_dv, e_dv, e_db); end
    checks++;
    if (t_done !== e_done) begin errors++; $display("FAIL flip_done done=%h expected %h", t_done, e_done); end
    checks++;
    if (err_end !== 4'(e_err)) begin errors++; $display("FAIL flip_err got=%0d expected=%0d", err_end, e_err); end
  endtask

  task automatic test_gaps;
    model(8, 2, 64'hAAAA_AAAA_AAAA_AAAA, 8'hB2, 8'h00);
    run_frame(64'hAAAA_AAAA_AAAA_AAAA, 8'hB2, 8'h00, 64'h1, -1);
    checks++;
    if (err1 !== 4'd0) begin errors++; $display("FAIL gaps_err_clear got=%0d expected=0", err1); end
    checks++;
    if (t_rdy !== e_rdy || t_busy !== e_busy || t_done !== e_done) begin errors++; $display("FAIL gaps_ctrl rdy=%h busy=%h done=%h expected %h %h %h", t_rdy, t_busy, t_done, e_rdy, e_busy, e_done); end
    checks++;
    if (t_en !== e_en || (t_d & e_en) !== e_d) begin errors++; $display("FAIL gaps_enc en=%h d=%h expected en=%h d=%h", t_en, t_d & e_en, e_en, e_d); end
    checks++;
    if (t_dv !== e_dv || (t_db & e_dv) !== e_db) begin errors++; $display("FAIL gaps_dec dv=%h db=%h expected dv=%h db=%h", t_dv, t_db & e_dv, e_dv, e_db); end
  endtask

  task automatic test_ignored_start;
    logic [63:0] sp;
    sp = (64'h1 << 16) | (64'h1 << 3) | 64'h1;
    model(8, 2, 64'hFFFF_FFFF_FFFF_FFFE, 8'h6C, 8'h00);
    run_frame(64'hFFFF_FFFF_FFFF_FFFE, 8'h6C, 8'h00, sp, -1);
    checks++;
    if (t_rdy !== e_rdy || t_busy !== e_busy || t_done !== e_done) begin errors++; $display("FAIL ign_ctrl rdy=%h busy=%h done=%h expected %h %h %h", t_rdy, t_busy, t_done, e_rdy, e_busy, e_done); end
    checks++;
    if (t_en !== e_en || (t_d & e_en) !== e_d) begin errors++; $display("FAIL ign_enc en=%h d=%h expected en=%h d=%h", t_en, t_d & e_en, e_en, e_d); end
    checks++;
    if (t_dv !== e_dv || (t_db & e_dv) !== e_db) begin errors++; $display("FAIL ign_dec dv=%h db=%h expected dv=%h db=%h", t_dv, t_db & e_dv, e_dv, e_db); end
  endtask

  task automatic test_reset_drain;
    run_frame(64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 8'h00, 64'h1, 12);
    checks++;
    if (snap !== '0) begin errors++; $display("FAIL drain_rst outputs=%h expected 0", snap); end
    checks++;
    if (t_done !== '0) begin errors++; $display("FAIL drain_nodone done=%h expected 0", t_done); end
    model(8, 2, 64'hFFFF_FFFF_FFFF_FFFE, 8'h93, 8'h00);
    run_frame(64'hFFFF_FFFF_FFFF_FFFE, 8'h93, 8'h00, 64'h1, -1);
    checks++;
    if (t_dv !== e_dv || (t_db & e_dv) !== e_db) begin errors++; $display("FAIL drain_next_dec dv=%h db=%h expected dv=%h db=%h", t_dv, t_db & e_dv, e_dv, e_db); end
    checks++;
    if (t_done !== e_done || err_end !== 4'(e_err)) begin errors++; $display("FAIL drain_next_done done=%h err=%0d expected %h %0d", t_done, err_end, e_done, e_err); end
  endtask

  task automatic test_short;
    sel = 1'b1;
    model(2, 0, 64'hFFFF_FFFF_FFFF_FFFE, 8'h02, 8'h00);
    run_frame(64'hFFFF_FFFF_FFFF_FFFE, 8'h02, 8'h00, 64'h1, -1);
    checks++;
    if (t_en !== e_en || (t_d & e_en) !== e_d || $countones(t_en) != 2) begin errors++; $display("FAIL short_enc en=%h d=%h expected en=%h d=%h", t_en, t_d & e_en, e_en, e_d); end
    checks++;
    if (t_dv !== e_dv || (t_db & e_dv) !== e_db) begin errors++; $display("FAIL short_dec dv=%h db=%h expected dv=%h db=%h", t_dv, t_db & e_dv, e_dv, e_db); end
    checks++;
    if (t_rdy !== e_rdy || t_busy !== e_busy || t_done !== e_done) begin errors++; $display("FAIL short_ctrl rdy=%h busy=%h done=%h expected %h %h %h", t_rdy, t_busy, t_done, e_rdy, e_busy, e_done); end
    model(2, 0, 64'hFFFF_FFFF_FFFF_FFFE, 8'h01, 8'h01);
    run_frame(64'hFFFF_FFFF_FFFF_FFFE, 8'h01, 8'h01, 64'h1, -1);
    checks++;
    if (err_end !== 4'(e_err)) begin errors++; $display("FAIL short_err got=%0d expected=%0d", err_end, e_err); end
    sel = 1'b0;
  endtask

  task automatic test_random;
    logic [63:0] vp;
    logic [7:0] bits, fm;
    for (int i = 0; i < 4; i++) begin
      vp = ({$urandom, $urandom} | (~64'h0 << 33)) & ~64'h1;
      bits = 8'($urandom);
      fm = 8'($urandom_range(0, 255));
      model(8, 2, vp, bits, fm);
      run_frame(vp, bits, fm, 64'h1, -1);
      checks++;
      if (t_en !== e_en || (t_d & e_en) !== e_d) begin errors++; $display("FAIL rand%0d_enc en=%h d=%h expected en=%h d=%h", i, t_en, t_d & e_en, e_en, e_d); end
      checks++;
      if (t_dv !== e_dv || (t_db & e_dv) !== e_db) begin errors++; $display("FAIL rand%0d_dec dv=%h db=%h expected dv=%h db=%h", i, t_dv, t_db & e_dv, e_dv, e_db); end
      checks++;
      if (t_rdy !== e_rdy || t_busy !== e_busy || t_done !== e_done) begin errors++; $display("FAIL rand%0d_ctrl rdy=%h busy=%h done=%h expected %h %h %h", i, t_rdy, t_busy, t_done, e_rdy, e_busy, e_done); end
      checks++;
      if (err_end !== 4'(e_err)) begin errors++; $display("FAIL rand%0d_err got=%0d expected=%0d", i, err_end, e_err); end
    end
  endtask

  initial begin
    test_reset;
    test_continuous;
    test_flip;
    test_gaps;
    test_ignored_start;
    test_reset_drain;
    test_short;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
